// File: rtl/team_06_pkg.sv
// Shared definitions for the team_06 audio path: sample/address widths,
// the echo FSM state type and the default echo lookback distance.
package team_06_pkg;

  localparam int SAMPLE_W = 8;
  localparam int ADDR_W   = 13;

  localparam logic [ADDR_W-1:0] DEFAULT_DELAY = 13'd4000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    CAPTURE = 2'd2
  } echo_state_t;

endpackage

// File: rtl/echo_mixer.sv
// Combinational floor average of two unsigned samples; the sum is formed
// at 9 bits so the halved result always fits back into a sample.
module echo_mixer
  import team_06_pkg::*;
(
  input  logic [SAMPLE_W-1:0] a,
  input  logic [SAMPLE_W-1:0] b,
  output logic [SAMPLE_W-1:0] avg
);

  assign avg = SAMPLE_W'(({1'b0, a} + {1'b0, b}) >> 1);

endmodule

// File: rtl/echo_effect.sv
// Echo mixer: per request, fetches a past output sample from delay memory
// and averages it with the live input; bypasses while idle or warming up.
module echo_effect
  import team_06_pkg::*;
#(
  parameter logic [ADDR_W-1:0] DELAY_SAMPLES = DEFAULT_DELAY
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] audio_in,
  input  logic                search_enable,
  input  logic [SAMPLE_W-1:0] past_output,
  output logic [ADDR_W-1:0]   offset,
  output logic                search,
  output logic [SAMPLE_W-1:0] echo_out,
  output logic [SAMPLE_W-1:0] save_audio
);

  echo_state_t         r_state;
  echo_state_t         w_state_next;
  logic [SAMPLE_W-1:0] r_echo;
  logic [SAMPLE_W-1:0] r_save;
  logic                r_search;
  logic [ADDR_W-1:0]   r_offset;
  logic [ADDR_W-1:0]   r_count;

  logic [SAMPLE_W-1:0] w_echo_next;
  logic                w_search_next;
  logic [ADDR_W-1:0]   w_offset_next;
  logic [ADDR_W-1:0]   w_count_next;
  logic [SAMPLE_W-1:0] w_mix;

  echo_mixer u_mixer (
    .a   (audio_in),
    .b   (past_output),
    .avg (w_mix)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_echo_next   = r_echo;
    w_search_next = 1'b0;
    w_offset_next = '0;
    w_count_next  = r_count;
    case (r_state)
      IDLE: begin
        if (search_enable) begin
          w_state_next = FETCH;
        end else begin
          w_echo_next = audio_in;
        end
      end
      FETCH: begin
        w_search_next = 1'b1;
        w_offset_next = DELAY_SAMPLES;
        w_state_next  = CAPTURE;
      end
      CAPTURE: begin
        // Until the delay line holds DELAY_SAMPLES outputs the memory data is stale.
        if (r_count >= DELAY_SAMPLES) begin
          w_echo_next = w_mix;
        end else begin
          w_echo_next  = audio_in;
          w_count_next = r_count + 13'd1;
        end
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_echo   <= '0;
      r_save   <= '0;
      r_search <= 1'b0;
      r_offset <= '0;
      r_count  <= '0;
    end else begin
      r_echo   <= w_echo_next;
      r_save   <= w_echo_next;
      r_search <= w_search_next;
      r_offset <= w_offset_next;
      r_count  <= w_count_next;
    end
  end

  assign echo_out   = r_echo;
  assign save_audio = r_save;
  assign search     = r_search;
  assign offset     = r_offset;

endmodule

// File: tb/tb_echo_effect.sv
// Directed bench for echo_effect with a 2-sample delay line: reset, bypass,
// warm-up, table of mixing vectors, request pacing and async reset abort.
module tb_echo_effect;

  localparam logic [12:0] DLY = 13'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  audio_in;
  logic        search_enable;
  logic [7:0]  past_output;
  logic [12:0] offset;
  logic        search;
  logic [7:0]  echo_out;
  logic [7:0]  save_audio;

  int n_vec = 0;
  int n_err = 0;

  echo_effect #(.DELAY_SAMPLES(DLY)) dut (
    .clk           (clk),
    .rst           (rst),
    .audio_in      (audio_in),
    .search_enable (search_enable),
    .past_output   (past_output),
    .offset        (offset),
    .search        (search),
    .echo_out      (echo_out),
    .save_audio    (save_audio)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] p;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // One request from IDLE; search_enable is dropped during FETCH on purpose.
  task automatic txn(input logic [7:0] a, input logic [7:0] p, input logic [7:0] exp,
                     input string name);
    audio_in      = a;
    past_output   = p;
    search_enable = 1'b1;
    @(posedge clk); #1;
    search_enable = 1'b0;
    check({name, " search_idle"}, int'(search), 0);
    @(posedge clk); #1;
    check({name, " search_pulse"}, int'(search), 1);
    check({name, " offset"}, int'(offset), int'(DLY));
    @(posedge clk); #1;
    check({name, " echo_out"}, int'(echo_out), int'(exp));
    check({name, " save_audio"}, int'(save_audio), int'(exp));
    check({name, " search_drop"}, int'(search), 0);
  endtask

  initial begin
    int pulses;
    int last_edge;
    int bad_gap;
    int seen;

    tbl[0] = '{a: 8'd78,  p: 8'd89,  exp: 8'd78};
    tbl[1] = '{a: 8'd78,  p: 8'd89,  exp: 8'd78};
    tbl[2] = '{a: 8'd78,  p: 8'd89,  exp: 8'd83};
    tbl[3] = '{a: 8'd255, p: 8'd255, exp: 8'd255};
    tbl[4] = '{a: 8'd254, p: 8'd255, exp: 8'd254};
    tbl[5] = '{a: 8'd12,  p: 8'd255, exp: 8'd133};
    tbl[6] = '{a: 8'd65,  p: 8'd56,  exp: 8'd60};
    tbl[7] = '{a: 8'd68,  p: 8'd50,  exp: 8'd59};

    // Reset held with a request pending: nothing may move.
    rst = 1'b0; search_enable = 1'b1; audio_in = 8'd68; past_output = 8'd50;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (search) seen++;
    end
    check("reset search_seen", seen, 0);
    check("reset echo_out", int'(echo_out), 0);
    check("reset save_audio", int'(save_audio), 0);
    check("reset offset", int'(offset), 0);

    // Bypass.
    search_enable = 1'b0; audio_in = 8'd75; rst = 1'b1;
    @(posedge clk); #1;
    check("bypass echo_out", int'(echo_out), 75);
    check("bypass save_audio", int'(save_audio), 75);
    check("bypass search", int'(search), 0);
    check("bypass offset", int'(offset), 0);

    // Warm-up then mixing; bypass cycles between requests keep the counter.
    for (int i = 0; i < 8; i++) begin
      txn(tbl[i].a, tbl[i].p, tbl[i].exp, $sformatf("vec%0d", i));
      audio_in = 8'd9;
      @(posedge clk); #1;
      check($sformatf("vec%0d bypass", i), int'(echo_out), 9);
    end

    // Held request: pulses every third cycle, each one cycle long.
    audio_in = 8'd200; past_output = 8'd100; search_enable = 1'b1;
    pulses = 0; last_edge = -10; bad_gap = 0;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
      if (search) begin
        if (pulses > 0 && e - last_edge != 3) bad_gap++;
        pulses++;
        last_edge = e;
      end
    end
    search_enable = 1'b0;
    check("held pulse_count", pulses, 4);
    check("held bad_gaps", bad_gap, 0);
    check("held echo_out", int'(echo_out), 150);

    // Async reset during CAPTURE clears outputs without a clock edge.
    search_enable = 1'b1;
    @(posedge clk); #1;
    search_enable = 1'b0;
    @(posedge clk); #1;
    check("abort search_before", int'(search), 1);
    #2;
    rst = 1'b0;
    #1;
    check("abort echo_out", int'(echo_out), 0);
    check("abort save_audio", int'(save_audio), 0);
    check("abort search", int'(search), 0);
    check("abort offset", int'(offset), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    // Counter restarted: first two results are pass-through again.
    txn(8'd78, 8'd89, 8'd78, "restart0");
    txn(8'd78, 8'd89, 8'd78, "restart1");
    txn(8'd78, 8'd89, 8'd83, "restart2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
